// File: rtl/bitslip_align_ctrl.sv
// Word-alignment training controller for one LVDS channel: slips the muxer one
// position at a time until the training word is seen MATCH_COUNT times in a row.
module bitslip_align_ctrl #(
  parameter int          DATAWIDTH     = 10,
  parameter logic [9:0]  TRAINPATTERN  = 10'h3A6,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          MATCH_COUNT   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] din,
  output logic                 bitslip,
  output logic                 busy,
  output logic                 locked,
  output logic                 failed,
  output logic [3:0]           slip_count
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DATAWIDTH-1:0] PATTERN     = TRAINPATTERN[DATAWIDTH-1:0];
  localparam logic [3:0]           LAST_SLIP   = 4'(DATAWIDTH - 1);
  localparam logic [3:0]           MATCH_TGT   = 4'(MATCH_COUNT);
  localparam logic [SW-1:0]        SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    SETTLE = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    match_cnt_reg, match_cnt_next;
  logic [3:0]    slip_count_reg, slip_count_next;
  logic [SW-1:0] settle_cnt_reg, settle_cnt_next;
  logic          bitslip_reg, bitslip_next;
  logic          busy_reg, busy_next;
  logic          locked_reg, locked_next;
  logic          failed_reg, failed_next;
  logic          match_hit;

  assign match_hit = (din == PATTERN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      match_cnt_reg  <= '0;
      slip_count_reg <= '0;
      settle_cnt_reg <= '0;
      bitslip_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      locked_reg     <= 1'b0;
      failed_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      match_cnt_reg  <= match_cnt_next;
      slip_count_reg <= slip_count_next;
      settle_cnt_reg <= settle_cnt_next;
      bitslip_reg    <= bitslip_next;
      busy_reg       <= busy_next;
      locked_reg     <= locked_next;
      failed_reg     <= failed_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    match_cnt_next  = match_cnt_reg;
    slip_count_next = slip_count_reg;
    settle_cnt_next = settle_cnt_reg;
    case (state_reg)
      // Restart keeps the muxer where it is; the new run walks from there.
      IDLE, LOCKED, FAIL: begin
        if (start) begin
          state_next      = CHECK;
          slip_count_next = '0;
          match_cnt_next  = '0;
        end
      end
      CHECK: begin
        if (match_hit) begin
          match_cnt_next = match_cnt_reg + 4'd1;
          if (match_cnt_reg + 4'd1 == MATCH_TGT)
            state_next = LOCKED;
        end else if (slip_count_reg < LAST_SLIP) begin
          match_cnt_next = '0;
          state_next     = SLIP;
        end else begin
          slip_count_next = LAST_SLIP;
          state_next      = FAIL;
        end
      end
      SLIP: begin
        slip_count_next = slip_count_reg + 4'd1;
        settle_cnt_next = SETTLE_LOAD;
        state_next      = SETTLE;
      end
      SETTLE: begin
        settle_cnt_next = settle_cnt_reg - SW'(1);
        if (settle_cnt_reg <= SW'(1)) begin
          match_cnt_next = '0;
          state_next     = CHECK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    bitslip_next = (state_next == SLIP);
    busy_next    = (state_next == CHECK) || (state_next == SLIP) || (state_next == SETTLE);
    locked_next  = (state_next == LOCKED);
    failed_next  = (state_next == FAIL);
  end

  assign bitslip    = bitslip_reg;
  assign busy       = busy_reg;
  assign locked     = locked_reg;
  assign failed     = failed_reg;
  assign slip_count = slip_count_reg;

endmodule

// File: tb/tb_bitslip_align_ctrl.sv
// Bench for bitslip_align_ctrl: a rotating-muxer model feeds din and a
// scoreboard holds the expected end-of-training result for each run.
module tb_bitslip_align_ctrl;

  localparam logic [9:0] PAT = 10'h3A6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] din;
  logic       bitslip, busy, locked, failed;
  logic [3:0] slip_count;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int pulse_total = 0;
  int pulse_cyc[$];
  int base_off = 0;
  bit use_model = 1'b1;
  logic [9:0] din_force = '0;

  typedef struct {
    logic       locked;
    logic       failed;
    logic [3:0] slip_count;
  } exp_t;
  exp_t exp_q[$];

  bitslip_align_ctrl #(
    .DATAWIDTH(10), .TRAINPATTERN(10'h3A6), .SETTLE_CYCLES(4), .MATCH_COUNT(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .bitslip(bitslip), .busy(busy), .locked(locked), .failed(failed),
    .slip_count(slip_count)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] rot(input logic [9:0] p, input int k);
    logic [19:0] d;
    d = {p, p};
    d = d >> (10 - k);
    return d[9:0];
  endfunction

  // Muxer model: each sampled bitslip advances the rotation by one position.
  assign din = use_model ? rot(PAT, (base_off + pulse_total) % 10) : din_force;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bitslip === 1'b1) begin
      pulse_total <= pulse_total + 1;
      pulse_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_offset(input int target);
    base_off = (target - (pulse_total % 10) + 10) % 10;
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit timed_out, output int cycles);
    timed_out = 1'b1;
    cycles = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (locked === 1'b1 || failed === 1'b1) begin
        timed_out = 1'b0;
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic wait_pulse(input int limit, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bitslip === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bitslip, busy, locked, failed, slip_count} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000000", {bitslip, busy, locked, failed, slip_count});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bitslip, busy, locked, failed, slip_count} !== 8'h00) begin
      n_fail++;
      $display("FAIL idle_outputs: got %b expected 00000000", {bitslip, busy, locked, failed, slip_count});
    end
    $display("test_reset done");
  endtask

  task automatic test_aligned;
    int p0;
    exp_t e;
    use_model = 1'b1;
    set_offset(0);
    p0 = pulse_total;
    exp_q.push_back('{1'b1, 1'b0, 4'd0});
    pulse_start;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (busy !== 1'b1 || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL aligned_busy[%0d]: got busy=%b locked=%b expected busy=1 locked=0", i, busy, locked);
      end
      @(negedge clk);
    end
    n_checks++;
    if (locked !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL aligned_lock_latency: got locked=%b busy=%b expected locked=1 busy=0", locked, busy);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({locked, failed, slip_count} !== {e.locked, e.failed, e.slip_count}) begin
        n_fail++;
        $display("FAIL aligned_result: got l=%b f=%b sc=%0d expected l=%b f=%b sc=%0d",
                 locked, failed, slip_count, e.locked, e.failed, e.slip_count);
      end
    end
    n_checks++;
    if (pulse_total - p0 !== 0) begin
      n_fail++;
      $display("FAIL aligned_pulses: got %0d expected 0", pulse_total - p0);
    end
    $display("test_aligned: locked=%b slip_count=%0d", locked, slip_count);
  endtask

  task automatic test_misaligned;
    int p0, q0, n, bad;
    bit to;
    exp_t e;
    use_model = 1'b1;
    set_offset(7);
    p0 = pulse_total;
    q0 = pulse_cyc.size();
    exp_q.push_back('{1'b1, 1'b0, 4'd3});
    pulse_start;
    wait_done(200, to, n);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL misaligned_timeout: got no lock expected lock within 200 cycles");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({locked, failed, slip_count} !== {e.locked, e.failed, e.slip_count}) begin
        n_fail++;
        $display("FAIL misaligned_result: got l=%b f=%b sc=%0d expected l=%b f=%b sc=%0d",
                 locked, failed, slip_count, e.locked, e.failed, e.slip_count);
      end
    end
    n_checks++;
    if (pulse_total - p0 !== 3) begin
      n_fail++;
      $display("FAIL misaligned_pulses: got %0d expected 3", pulse_total - p0);
    end
    bad = 0;
    for (int i = q0 + 1; i < pulse_cyc.size(); i++)
      if (pulse_cyc[i] - pulse_cyc[i-1] < 5) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL misaligned_pulse_gap: got %0d short gaps expected 0", bad);
    end
    if (pulse_cyc.size() > q0) begin
      n_checks++;
      if (cyc - pulse_cyc[pulse_cyc.size()-1] !== 8) begin
        n_fail++;
        $display("FAIL settle_to_lock: got %0d cycles expected 8", cyc - pulse_cyc[pulse_cyc.size()-1]);
      end
    end
    $display("test_misaligned: locked=%b slip_count=%0d pulses=%0d", locked, slip_count, pulse_total - p0);
  endtask

  task automatic test_no_pattern;
    int p0, n, bad;
    bit to;
    exp_t e;
    use_model = 1'b0;
    din_force = 10'h000;
    p0 = pulse_total;
    exp_q.push_back('{1'b0, 1'b1, 4'd9});
    pulse_start;
    wait_done(300, to, n);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL nopat_timeout: got no end expected failed within 300 cycles");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({locked, failed, slip_count} !== {e.locked, e.failed, e.slip_count} || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL nopat_result: got l=%b f=%b sc=%0d busy=%b expected l=%b f=%b sc=%0d busy=0",
                 locked, failed, slip_count, busy, e.locked, e.failed, e.slip_count);
      end
    end
    n_checks++;
    if (pulse_total - p0 !== 9) begin
      n_fail++;
      $display("FAIL nopat_pulses: got %0d expected 9", pulse_total - p0);
    end
    p0 = pulse_total;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({bitslip, busy, locked, failed, slip_count} !== 8'b0001_1001) bad++;
    end
    n_checks++;
    if (bad !== 0 || pulse_total !== p0) begin
      n_fail++;
      $display("FAIL nopat_hold: got %0d bad cycles %0d pulses expected 0 and 0", bad, pulse_total - p0);
    end
    $display("test_no_pattern: failed=%b slip_count=%0d", failed, slip_count);
  endtask

  task automatic test_glitch;
    int p0, n;
    bit to;
    exp_t e;
    use_model = 1'b0;
    din_force = PAT;
    p0 = pulse_total;
    exp_q.push_back('{1'b1, 1'b0, 4'd1});
    pulse_start;
    repeat (3) @(negedge clk);
    din_force = 10'h155;
    @(negedge clk);
    n_checks++;
    if (locked !== 1'b0 || bitslip !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_slip: got locked=%b bitslip=%b expected locked=0 bitslip=1", locked, bitslip);
    end
    din_force = PAT;
    wait_done(100, to, n);
    n_checks++;
    if (to || n !== 8) begin
      n_fail++;
      $display("FAIL glitch_lock_time: got timeout=%b cycles=%0d expected timeout=0 cycles=8", to, n);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({locked, failed, slip_count} !== {e.locked, e.failed, e.slip_count}) begin
        n_fail++;
        $display("FAIL glitch_result: got l=%b f=%b sc=%0d expected l=%b f=%b sc=%0d",
                 locked, failed, slip_count, e.locked, e.failed, e.slip_count);
      end
    end
    n_checks++;
    if (pulse_total - p0 !== 1) begin
      n_fail++;
      $display("FAIL glitch_pulses: got %0d expected 1", pulse_total - p0);
    end
    $display("test_glitch: locked=%b slip_count=%0d", locked, slip_count);
  endtask

  task automatic test_control;
    int p0, n;
    bit to;
    exp_t e;
    use_model = 1'b1;
    set_offset(5);
    pulse_start;
    wait_pulse(50, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL ctrl_first_pulse: got none expected a bitslip pulse");
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bitslip, busy, locked, failed, slip_count} !== 8'h00) begin
      n_fail++;
      $display("FAIL ctrl_reset_mid_slip: got %b expected 00000000", {bitslip, busy, locked, failed, slip_count});
    end
    p0 = pulse_total;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (pulse_total !== p0 || busy !== 1'b0 || slip_count !== 4'd0) begin
      n_fail++;
      $display("FAIL ctrl_after_reset: got pulses=%0d busy=%b sc=%0d expected 0 0 0",
               pulse_total - p0, busy, slip_count);
    end

    set_offset(7);
    p0 = pulse_total;
    exp_q.push_back('{1'b1, 1'b0, 4'd3});
    pulse_start;
    wait_pulse(50, to);
    pulse_start;
    n_checks++;
    if (to || slip_count !== 4'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ctrl_start_while_busy: got timeout=%b sc=%0d busy=%b expected 0 1 1", to, slip_count, busy);
    end
    wait_done(200, to, n);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (to || {locked, failed, slip_count} !== {e.locked, e.failed, e.slip_count}) begin
        n_fail++;
        $display("FAIL ctrl_result: got l=%b f=%b sc=%0d expected l=%b f=%b sc=%0d",
                 locked, failed, slip_count, e.locked, e.failed, e.slip_count);
      end
    end
    n_checks++;
    if (pulse_total - p0 !== 3) begin
      n_fail++;
      $display("FAIL ctrl_pulses: got %0d expected 3", pulse_total - p0);
    end
    $display("test_control: locked=%b slip_count=%0d", locked, slip_count);
  endtask

  task automatic test_retrain;
    int p0, n;
    bit to;
    exp_t e;
    n_checks++;
    if (locked !== 1'b1 || slip_count !== 4'd3) begin
      n_fail++;
      $display("FAIL retrain_precond: got locked=%b sc=%0d expected 1 3", locked, slip_count);
    end
    use_model = 1'b1;
    set_offset(4);
    p0 = pulse_total;
    exp_q.push_back('{1'b1, 1'b0, 4'd6});
    pulse_start;
    n_checks++;
    if (locked !== 1'b0 || busy !== 1'b1 || slip_count !== 4'd0) begin
      n_fail++;
      $display("FAIL retrain_start: got locked=%b busy=%b sc=%0d expected 0 1 0", locked, busy, slip_count);
    end
    wait_done(200, to, n);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (to || {locked, failed, slip_count} !== {e.locked, e.failed, e.slip_count}) begin
        n_fail++;
        $display("FAIL retrain_result: got l=%b f=%b sc=%0d expected l=%b f=%b sc=%0d",
                 locked, failed, slip_count, e.locked, e.failed, e.slip_count);
      end
    end
    n_checks++;
    if (pulse_total - p0 !== 6) begin
      n_fail++;
      $display("FAIL retrain_pulses: got %0d expected 6", pulse_total - p0);
    end
    $display("test_retrain: locked=%b slip_count=%0d", locked, slip_count);
  endtask

  initial begin
    test_reset;
    test_aligned;
    test_misaligned;
    test_no_pattern;
    test_glitch;
    test_control;
    test_retrain;
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitslip_align_ctrl.md
Name: bitslip_align_ctrl

Overview:
- Word-alignment training controller for one LVDS channel.
- Drives the bitslip input of the per-channel bitslip muxer and watches the muxer's aligned output during sensor training.
- Issues single-cycle bitslip pulses until the output shows the training word for MATCH_COUNT consecutive cycles, then reports lock.
- Reports failure if no alignment matches after all DATAWIDTH positions have been tried.

Parameters:
- DATAWIDTH, 10, deserialized word width; supported values 4, 8, 10.
- TRAINPATTERN, 10'h3A6, expected training word; low DATAWIDTH bits are used.
- SETTLE_CYCLES, 4, wait cycles after each bitslip pulse before comparing again; minimum 2 (muxer latency).
- MATCH_COUNT, 4, consecutive matching words required for lock; range 1..15.

Ports:
- clk, input, 1, global clock, shared with the bitslip muxer.
- reset, input, 1, synchronous, active-high.
- start, input, 1, single-cycle request to (re)start training.
- din, input, DATAWIDTH, aligned word from the bitslip muxer output.
- bitslip, output, 1, single-cycle slip pulse to the muxer.
- busy, output, 1, high while training is in progress.
- locked, output, 1, high when alignment is achieved.
- failed, output, 1, high when all positions were tried without a match.
- slip_count, output, 4, number of slips issued in the current or last training run.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- All outputs are registered.
- Reset values: bitslip=0, busy=0, locked=0, failed=0, slip_count=0, state=IDLE, internal counters 0.
- States: IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL.
- IDLE:
  - start=1 → CHECK.
  - On that transition: slip_count=0, match_cnt=0, busy=1, locked=0, failed=0.
- CHECK: din is compared with TRAINPATTERN[DATAWIDTH-1:0] every cycle.
  - Match: match_cnt+1. When the incremented value equals MATCH_COUNT → LOCKED.
  - Mismatch with slip_count < DATAWIDTH-1: match_cnt=0 → SLIP.
  - Mismatch with slip_count = DATAWIDTH-1: → FAIL (DATAWIDTH positions tried, including the initial one).
  - The current alignment is always tested first; an already-aligned channel never receives a bitslip.
- SLIP:
  - bitslip=1 for exactly this one cycle.
  - slip_count+1.
  - settle_cnt loaded with SETTLE_CYCLES-1 → SETTLE.
- SETTLE:
  - bitslip=0 and din is ignored.
  - Decrement settle_cnt; at 0 → CHECK with match_cnt=0.
  - Total gap from the bitslip pulse to the first compared word is SETTLE_CYCLES cycles.
- LOCKED:
  - locked=1, busy=0, slip_count held.
  - State is sticky; din is not monitored.
- FAIL:
  - failed=1, busy=0, slip_count=DATAWIDTH-1.
  - State is sticky.
- start handling:
  - start in LOCKED or FAIL → CHECK, with the same initialisation as from IDLE.
  - The muxer position is not reset, so the retry walks all positions from the current one.
  - start while busy=1 is ignored.
- Latency: start sampled at edge N → first compare at edge N+1.
  - With din already aligned, locked=1 after edge N+MATCH_COUNT.
- bitslip is never high on two consecutive cycles and never high outside SLIP.
- locked and failed are mutually exclusive; busy=0 whenever either is high.
- Reset in any state, including mid-SLIP: bitslip=0 from the next cycle and state=IDLE; reset overrides start.
- slip_count never exceeds DATAWIDTH-1.
- MATCH_COUNT=1: lock on the first matching word.

Test Plan:
All scenarios use DATAWIDTH=10, TRAINPATTERN=0x3A6, SETTLE_CYCLES=4, MATCH_COUNT=4, and the bench runs a behavioural rotating muxer model.
1. Aligned: model offset 0, start pulse at edge N → zero bitslip pulses; locked=1 after edge N+4; slip_count=0; busy high from N+1 to N+3.
2. Misaligned: model offset needing 3 slips → exactly 3 single-cycle bitslip pulses, each followed by at least 4 cycles without a pulse; then locked=1, slip_count=3, failed=0.
3. No pattern: din held at 0x000 → exactly 9 bitslip pulses; failed=1, locked=0, busy=0, slip_count=9; outputs hold for 100 cycles.
4. Glitch: din = 3×0x3A6, then 0x155, then 0x3A6 → match counter clears and one bitslip is issued; lock only after 4 fresh consecutive matches.
5. Control: reset asserted one cycle after a SLIP pulse → all outputs 0 next cycle and no further bitslip; a start pulse issued while busy does not restart the run (slip_count sequence unchanged).
6. Retrain: from LOCKED with slip_count=3, shift the model offset and pulse start → locked=0 next cycle, busy=1, slip_count=0, then re-locks at the new offset.
